opc7_timer_intc: RTL



---
 rtl/opc7_timer_intc.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/opc7_timer_intc.sv
// opc7_timer_intc
// I/O-space responder for the OPC7 CPU: a 32-bit prescaled down-counter timer
// and an 8-input rising-edge interrupt controller in a 16-word I/O window.
//
// Ports
//   clk       system clock, rising edge
//   reset_b   asynchronous active-low reset
//   clken     shared CPU clock enable; register state advances only when high
//   address   CPU address (20 bits); window selected by address[19:4]
//   wdata     CPU write data (dout)
//   rnw       1 = read, 0 = write
//   vio       CPU I/O cycle strobe
//   irq_in    external interrupt requests (asynchronous, rising-edge)
//   rdata     registered read data for the CPU din mux
//   rdata_en  rdata is valid this cycle
//   int_b     active-low interrupt requests: [1] external IRQs, [0] timer
//
// Bus protocol: a transfer is requested by vio=1 with a matching window address
// and completes on the first clken edge that samples it (no wait states). A
// write captures wdata at that edge; a read returns rdata with rdata_en=1 for
// exactly the following clken period. There is no back-pressure.

module opc7_timer_intc #(
  parameter logic [19:0] IO_BASE  = 20'h000F0,
  parameter logic [31:0] ID_VALUE = 32'h4F504337
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        clken,
  input  logic [19:0] address,
  input  logic [31:0] wdata,
  input  logic        rnw,
  input  logic        vio,
  input  logic [7:0]  irq_in,
  output logic [31:0] rdata,
  output logic        rdata_en,
  output logic [1:0]  int_b
);

  logic [31:0] load_q, count_q;
  logic [15:0] prescale_q, pre_q;
  logic [2:0]  ctrl_q;
  logic        expired_q;
  logic [7:0]  mask_q, pend_q;
  logic [7:0]  sync1_q, sync2_q, sync3_q, sticky_q;

  logic        sel, wr, rd;
  logic [3:0]  offset;
  logic        tick;
  logic [31:0] count_d;
  logic [15:0] pre_d;
  logic [2:0]  ctrl_d;
  logic        expired_d, expired_set, en_clear;
  logic [7:0]  irq_rise, pend_d;
  logic [31:0] rd_mux;

  assign sel    = vio && (address[19:4] == IO_BASE[19:4]);
  assign offset = address[3:0];
  assign wr     = sel && !rnw;
  assign rd     = sel && rnw;

  assign tick     = ctrl_q[0] && (pre_q == 16'd0);
  assign irq_rise = sync2_q & ~sync3_q;

  // Timer / prescaler next state. CPU writes are applied last so they win
  // over the tick and over the hardware EN clear on the same edge.
  always_comb begin
    count_d     = count_q;
    ctrl_d      = ctrl_q;
    pre_d       = pre_q;
    expired_set = 1'b0;
    en_clear    = 1'b0;

    if (ctrl_q[0]) begin
      pre_d = (pre_q == 16'd0) ? prescale_q : pre_q - 16'd1;
    end

    if (tick) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        count_d     = 32'd0;
        expired_set = 1'b1;
        en_clear    = !ctrl_q[1];
      end else if (ctrl_q[1]) begin
        count_d = load_q;
      end
    end

    if (en_clear) ctrl_d[0] = 1'b0;

    if (wr && (offset == 4'd0 || offset == 4'd1)) count_d = wdata;
    if (wr && offset == 4'd3)                     ctrl_d  = wdata[2:0];

    // Hardware set beats write-1-to-clear of the same bit.
    expired_d = (expired_q & ~(wr && offset == 4'd4 && wdata[0])) | expired_set;
    pend_d    = (pend_q & ~((wr && offset == 4'd6) ? wdata[7:0] : 8'h00))
                | irq_rise | sticky_q;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (offset)
      4'd0:    rd_mux = load_q;
      4'd1:    rd_mux = count_q;
      4'd2:    rd_mux = {16'd0, prescale_q};
      4'd3:    rd_mux = {29'd0, ctrl_q};
      4'd4:    rd_mux = {31'd0, expired_q};
      4'd5:    rd_mux = {24'd0, mask_q};
      4'd6:    rd_mux = {24'd0, pend_q};
      4'd7:    rd_mux = ID_VALUE;
      default: rd_mux = 32'd0;
    endcase
  end

  // Synchroniser and edge detector run on every clk. Edges seen while clken=0
  // accumulate in sticky_q and are folded into pend on the next clken edge.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync1_q  <= 8'h00;
      sync2_q  <= 8'h00;
      sync3_q  <= 8'h00;
      sticky_q <= 8'h00;
    end else begin
      sync1_q  <= irq_in;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      sticky_q <= clken ? 8'h00 : (sticky_q | irq_rise);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      load_q     <= 32'd0;
      count_q    <= 32'd0;
      prescale_q <= 16'd0;
      pre_q      <= 16'd0;
      ctrl_q     <= 3'd0;
      expired_q  <= 1'b0;
      mask_q     <= 8'h00;
      pend_q     <= 8'h00;
      rdata      <= 32'd0;
      rdata_en   <= 1'b0;
      int_b      <= 2'b11;
    end else if (clken) begin
      if (wr && offset == 4'd0) load_q     <= wdata;
      if (wr && offset == 4'd2) prescale_q <= wdata[15:0];
      if (wr && offset == 4'd5) mask_q     <= wdata[7:0];
      count_q   <= count_d;
      pre_q     <= pre_d;
      ctrl_q    <= ctrl_d;
      expired_q <= expired_d;
      pend_q    <= pend_d;
      if (rd) rdata <= rd_mux;
      rdata_en  <= rd;
      int_b[1]  <= ~|(pend_q & mask_q);
      int_b[0]  <= ~(expired_q & ctrl_q[2]);
    end
  end

endmodule
